// File: rtl/conv_row_scheduler_if.sv
// Pixel input stream and output-row handshake bundle for the
// convolution row scheduler.
interface conv_row_scheduler_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_row_valid;
    logic [5:0]            out_row_idx;
    logic                  out_row_ready;

    modport master (
        output in_valid, in_data, out_row_ready,
        input  in_ready, out_row_valid, out_row_idx
    );

    modport slave (
        input  in_valid, in_data, out_row_ready,
        output in_ready, out_row_valid, out_row_idx
    );
endinterface

// File: rtl/conv_row_scheduler.sv
// Layer sequencer: loads the feature map into a flat image register,
// then steps the selector row by row through conv and downstream handoff.
module conv_row_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1,
    parameter int SIZE       = 5,
    parameter int H          = 32,
    parameter int W          = 32,
    localparam int NPIX      = DEPTH * H * W,
    localparam int NROWS     = H - SIZE + 1,
    localparam int CW        = $clog2(NPIX)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_i,
    conv_row_scheduler_if.slave        bus,
    output logic [NPIX*DATA_WIDTH-1:0] image_o,
    output logic [5:0]                 row_o,
    output logic [5:0]                 column_o,
    output logic                       conv_start_o,
    input  logic                       conv_done_i,
    output logic                       busy_o,
    output logic                       done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SELECT,
        S_CONV,
        S_EMIT,
        S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [5:0]                 row_q, row_d;
    logic                       first_q, first_d;
    logic [NPIX*DATA_WIDTH-1:0] image_q;
    logic                       beat;

    assign beat = (state_q == S_LOAD) && bus.in_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        first_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(NPIX - 1)) begin
                        state_d = S_SELECT;
                        row_d   = '0;
                    end
                end
            end
            S_SELECT: begin
                state_d = S_CONV;
                first_d = 1'b1;
            end
            S_CONV: begin
                if (conv_done_i) state_d = S_EMIT;
            end
            S_EMIT: begin
                if (bus.out_row_ready) begin
                    if (row_q == 6'(NROWS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + 6'd1;
                        state_d = S_SELECT;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            first_q <= first_d;
        end
    end

    // Image is only written by load beats, so it stays valid after the pass
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            image_q <= '0;
        end else if (beat) begin
            image_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
        end
    end

    assign bus.in_ready      = (state_q == S_LOAD);
    assign bus.out_row_valid = (state_q == S_EMIT);
    assign bus.out_row_idx   = row_q;
    assign image_o           = image_q;
    assign row_o             = row_q;
    assign column_o          = 6'd0;
    assign conv_start_o      = (state_q == S_CONV) && first_q;
    assign busy_o            = (state_q != S_IDLE);
    assign done_o            = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed self-checking bench for conv_row_scheduler.
// Each scenario task drives stimulus and checks its own expectations.
module tb_conv_row_scheduler;
    localparam int DW    = 16;
    localparam int NPIX  = 1024;
    localparam int NROWS = 28;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 conv_done = 1'b0;
    logic [NPIX*DW-1:0]   image;
    logic [5:0]           row;
    logic [5:0]           column;
    logic                 conv_start;
    logic                 busy;
    logic                 done;
    int                   checks = 0;
    int                   errors = 0;

    conv_row_scheduler_if #(.DATA_WIDTH(DW)) bus ();

    conv_row_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .bus          (bus),
        .image_o      (image),
        .row_o        (row),
        .column_o     (column),
        .conv_start_o (conv_start),
        .conv_done_i  (conv_done),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams n pixels valued base+k, idling every third cycle
    task automatic do_load(input int n, input int base);
        int k;
        int c;
        k = 0;
        c = 0;
        while (k < n) begin
            if (c % 3 == 2) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = 16'(base + k);
                k++;
            end
            c++;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        #3 reset = 1'b0;
        tick();
        tick();
        outs = {busy, bus.in_ready, bus.out_row_valid, conv_start, done,
                row, column, bus.out_row_idx, 9'd0};
        checks++;
        if (outs !== 32'd0) begin
            errors++;
            $display("FAIL reset_outs got %h want 0", outs);
        end
        checks++;
        if (image !== '0) begin
            errors++;
            $display("FAIL reset_image got nonzero want 0");
        end
        reset = 1'b1;
        tick();
        start_pass();
        do_load(500, 16'h100);
        checks++;
        if (image[499*DW +: DW] !== 16'h100 + 16'd499) begin
            errors++;
            $display("FAIL partial_load got %h want %h",
                     image[499*DW +: DW], 16'h100 + 16'd499);
        end
        reset = 1'b0;
        #1;
        outs = {busy, bus.in_ready, bus.out_row_valid, conv_start, done,
                row, column, bus.out_row_idx, 9'd0};
        checks++;
        if (outs !== 32'd0) begin
            errors++;
            $display("FAIL midload_reset_outs got %h want 0", outs);
        end
        checks++;
        if (image !== '0) begin
            errors++;
            $display("FAIL midload_reset_image got nonzero want 0");
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load();
        int bad;
        int first_bad;
        start_pass();
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_entry in_ready %b busy %b want 1 1",
                     bus.in_ready, busy);
        end
        do_load(NPIX, 0);
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_exit in_ready %b busy %b want 0 1",
                     bus.in_ready, busy);
        end
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < NPIX; k++) begin
            if (image[k*DW +: DW] !== 16'(k)) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL load_image %0d bad pixels first at %0d got %h want %h",
                     bad, first_bad, image[first_bad*DW +: DW], 16'(first_bad));
        end
        checks++;
        if (row !== 6'd0) begin
            errors++;
            $display("FAIL load_row got %0d want 0", row);
        end
    endtask

    task automatic test_full_pass();
        int cs;
        int nv;
        int last;
        bit seen_done;
        bit col_bad;
        cs = 0;
        nv = 0;
        last = -1;
        seen_done = 1'b0;
        col_bad = 1'b0;
        conv_done = 1'b1;
        bus.out_row_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            tick();
            if (conv_start) cs++;
            if (column !== 6'd0) col_bad = 1'b1;
            if (bus.out_row_valid) begin
                checks++;
                if (bus.out_row_idx !== 6'(nv)) begin
                    errors++;
                    $display("FAIL pass_idx got %0d want %0d",
                             bus.out_row_idx, nv);
                end
                if (nv > 0) begin
                    checks++;
                    if (cyc - last != 3) begin
                        errors++;
                        $display("FAIL pass_spacing got %0d want 3",
                                 cyc - last);
                    end
                end
                last = cyc;
                nv++;
            end
            if (done) begin
                seen_done = 1'b1;
                checks++;
                if (cyc != last + 1) begin
                    errors++;
                    $display("FAIL pass_done_lat got %0d want %0d",
                             cyc, last + 1);
                end
            end
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL pass_timeout got no done want done");
        end
        checks++;
        if (nv != NROWS || cs != NROWS) begin
            errors++;
            $display("FAIL pass_counts rows %0d starts %0d want %0d %0d",
                     nv, cs, NROWS, NROWS);
        end
        checks++;
        if (col_bad) begin
            errors++;
            $display("FAIL pass_column got nonzero want 0");
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL pass_idle busy %b done %b want 0 0", busy, done);
        end
        conv_done = 1'b0;
        bus.out_row_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int nv;
        bit seen;
        bit seen_done;
        start_pass();
        do_load(NPIX, 16'h40);
        conv_done = 1'b1;
        bus.out_row_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (bus.out_row_valid && bus.out_row_idx == 6'd4) seen = 1'b1;
        end
        tick();
        bus.out_row_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (bus.out_row_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_timeout got no row5 valid want valid");
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_row_valid !== 1'b1 || bus.out_row_idx !== 6'd5 ||
                row !== 6'd5 || conv_start !== 1'b0 || column !== 6'd0) begin
                errors++;
                $display("FAIL bp_hold cyc %0d valid %b idx %0d row %0d cs %b want 1 5 5 0",
                         i, bus.out_row_valid, bus.out_row_idx, row, conv_start);
            end
            tick();
        end
        bus.out_row_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_row_valid !== 1'b0 || row !== 6'd6) begin
            errors++;
            $display("FAIL bp_release valid %b row %0d want 0 6",
                     bus.out_row_valid, row);
        end
        nv = 6;
        seen_done = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            tick();
            if (bus.out_row_valid) begin
                checks++;
                if (bus.out_row_idx !== 6'(nv)) begin
                    errors++;
                    $display("FAIL bp_idx got %0d want %0d",
                             bus.out_row_idx, nv);
                end
                nv++;
            end
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (!seen_done || nv != NROWS) begin
            errors++;
            $display("FAIL bp_total done %b rows %0d want 1 %0d",
                     seen_done, nv, NROWS);
        end
        conv_done = 1'b0;
        bus.out_row_ready = 1'b0;
    endtask

    task automatic test_spurious();
        int nv;
        bit seen_done;
        tick();
        conv_done = 1'b1;
        bus.out_row_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 16'hBEEF;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.out_row_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_spurious busy %b rdy %b valid %b want 0 0 0",
                     busy, bus.in_ready, bus.out_row_valid);
        end
        bus.in_valid = 1'b0;
        bus.out_row_ready = 1'b0;
        start_pass();
        do_load(300, 16'h200);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_row_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_spurious rdy %b valid %b want 1 0",
                     bus.in_ready, bus.out_row_valid);
        end
        conv_done = 1'b0;
        do_load(NPIX - 300, 16'h200 + 300);
        tick();
        checks++;
        if (conv_start !== 1'b1) begin
            errors++;
            $display("FAIL conv_entry conv_start %b want 1", conv_start);
        end
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 16'hFFFF;
        bus.out_row_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b1 || bus.out_row_valid !== 1'b0 ||
                bus.in_ready !== 1'b0 || row !== 6'd0 ||
                conv_start !== 1'b0) begin
                errors++;
                $display("FAIL conv_spurious cyc %0d busy %b valid %b rdy %b row %0d cs %b want 1 0 0 0 0",
                         i, busy, bus.out_row_valid, bus.in_ready, row, conv_start);
            end
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_row_ready = 1'b0;
        checks++;
        if (image[0 +: DW] !== 16'h200 ||
            image[(NPIX-1)*DW +: DW] !== 16'h5FF) begin
            errors++;
            $display("FAIL image_kept got %h %h want 0200 05ff",
                     image[0 +: DW], image[(NPIX-1)*DW +: DW]);
        end
        conv_done = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            conv_done = (i != 1);
            tick();
        end
        checks++;
        if (bus.out_row_valid !== 1'b1 || bus.out_row_idx !== 6'd0) begin
            errors++;
            $display("FAIL emit_spurious valid %b idx %0d want 1 0",
                     bus.out_row_valid, bus.out_row_idx);
        end
        conv_done = 1'b1;
        bus.out_row_ready = 1'b1;
        nv = 1;
        seen_done = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            tick();
            if (bus.out_row_valid) begin
                checks++;
                if (bus.out_row_idx !== 6'(nv)) begin
                    errors++;
                    $display("FAIL spur_idx got %0d want %0d",
                             bus.out_row_idx, nv);
                end
                nv++;
            end
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (!seen_done || nv != NROWS) begin
            errors++;
            $display("FAIL spur_total done %b rows %0d want 1 %0d",
                     seen_done, nv, NROWS);
        end
    endtask

    task automatic test_back_to_back();
        int nv;
        int cs;
        bit seen_done;
        tick();
        start_pass();
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_load rdy %b busy %b want 1 1",
                     bus.in_ready, busy);
        end
        do_load(NPIX, 16'h7000);
        nv = 0;
        cs = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            tick();
            if (conv_start) cs++;
            if (bus.out_row_valid) begin
                checks++;
                if (bus.out_row_idx !== 6'(nv)) begin
                    errors++;
                    $display("FAIL b2b_idx got %0d want %0d",
                             bus.out_row_idx, nv);
                end
                nv++;
            end
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (!seen_done || nv != NROWS || cs != NROWS) begin
            errors++;
            $display("FAIL b2b_total done %b rows %0d starts %0d want 1 %0d %0d",
                     seen_done, nv, cs, NROWS, NROWS);
        end
        checks++;
        if (image[3*DW +: DW] !== 16'h7003) begin
            errors++;
            $display("FAIL b2b_image got %h want 7003", image[3*DW +: DW]);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_row_ready = 1'b0;
        test_reset();
        test_load();
        test_full_pass();
        test_backpressure();
        test_spurious();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
